// File: rtl/rgb_cmd_decoder.sv
// SPI command decoder for the RGB cycle block: speed/enable registers,
// status read-back bytes and a saturating error counter.
// Ports: clk, rst (async, active-low), rx_valid/rx_data/rx_first/rx_end in;
//        tx_data, r/g/b_speed, enable, update, err_count out.
module rgb_cmd_decoder #(
   parameter logic [4:0] DEF_R  = 5'd3,
   parameter logic [4:0] DEF_G  = 5'd5,
   parameter logic [4:0] DEF_B  = 5'd7,
   parameter logic       DEF_EN = 1'b1,
   parameter int         ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   input  logic             rx_first,
   input  logic             rx_end,
   output logic [7:0]       tx_data,
   output logic [4:0]       r_speed,
   output logic [4:0]       g_speed,
   output logic [4:0]       b_speed,
   output logic             enable,
   output logic             update,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [2:0] {
      IDLE, SPD_R, SPD_G, SPD_B, ENA, STAT, DROP
   } state_t;

   state_t     state, state_n;
   logic [4:0] shadow_r, shadow_r_n;
   logic [4:0] shadow_g, shadow_g_n;
   logic [4:0] r_n, g_n, b_n;
   logic       en_n, upd_n;
   logic [7:0] tx_n;
   logic [4:0] snap_g, snap_g_n, snap_b, snap_b_n;
   logic       snap_en, snap_en_n;
   logic [7:0] snap_err, snap_err_n;
   logic [2:0] idx, idx_n;
   logic [ERR_W-1:0] err_n;
   logic [ERR_W:0]   esum;
   logic [1:0]       inc;
   logic             unk, abort, mid, byte_first, byte_data, completes;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         shadow_r  <= '0;
         shadow_g  <= '0;
         r_speed   <= DEF_R;
         g_speed   <= DEF_G;
         b_speed   <= DEF_B;
         enable    <= DEF_EN;
         update    <= 1'b0;
         tx_data   <= 8'h00;
         snap_g    <= '0;
         snap_b    <= '0;
         snap_en   <= 1'b0;
         snap_err  <= '0;
         idx       <= '0;
         err_count <= '0;
      end else begin
         state     <= state_n;
         shadow_r  <= shadow_r_n;
         shadow_g  <= shadow_g_n;
         r_speed   <= r_n;
         g_speed   <= g_n;
         b_speed   <= b_n;
         enable    <= en_n;
         update    <= upd_n;
         tx_data   <= tx_n;
         snap_g    <= snap_g_n;
         snap_b    <= snap_b_n;
         snap_en   <= snap_en_n;
         snap_err  <= snap_err_n;
         idx       <= idx_n;
         err_count <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      shadow_r_n = shadow_r;
      shadow_g_n = shadow_g;
      r_n        = r_speed;
      g_n        = g_speed;
      b_n        = b_speed;
      en_n       = enable;
      upd_n      = 1'b0;
      tx_n       = tx_data;
      snap_g_n   = snap_g;
      snap_b_n   = snap_b;
      snap_en_n  = snap_en;
      snap_err_n = snap_err;
      idx_n      = idx;
      unk        = 1'b0;
      byte_first = rx_valid & rx_first;
      byte_data  = rx_valid & ~rx_first;
      mid        = (state == SPD_R) || (state == SPD_G) ||
                   (state == SPD_B) || (state == ENA);
      completes  = byte_data && ((state == SPD_B) || (state == ENA));
      // a partial command dies either to a new first byte or to frame end
      abort      = mid && (byte_first || (rx_end && !completes));

      if (byte_first) begin
         tx_n = 8'h00;
         case (rx_data)
            8'h00: state_n = DROP;
            8'h01: state_n = SPD_R;
            8'h02: state_n = ENA;
            8'h03: begin
               state_n    = STAT;
               tx_n       = {3'b0, r_speed};
               snap_g_n   = g_speed;
               snap_b_n   = b_speed;
               snap_en_n  = enable;
               snap_err_n = 8'(err_count);
               idx_n      = 3'd1;
            end
            default: begin
               state_n = DROP;
               unk     = 1'b1;
            end
         endcase
      end else if (byte_data) begin
         unique case (state)
            SPD_R: begin
               shadow_r_n = rx_data[4:0];
               state_n    = SPD_G;
            end
            SPD_G: begin
               shadow_g_n = rx_data[4:0];
               state_n    = SPD_B;
            end
            SPD_B: begin
               r_n     = shadow_r;
               g_n     = shadow_g;
               b_n     = rx_data[4:0];
               upd_n   = 1'b1;
               state_n = DROP;
            end
            ENA: begin
               en_n    = rx_data[0];
               upd_n   = 1'b1;
               state_n = DROP;
            end
            STAT: begin
               case (idx)
                  3'd1:    tx_n = {3'b0, snap_g};
                  3'd2:    tx_n = {3'b0, snap_b};
                  3'd3:    tx_n = {7'b0, snap_en};
                  3'd4:    tx_n = snap_err;
                  default: tx_n = 8'h00;
               endcase
               if (idx != 3'd5) idx_n = idx + 3'd1;
            end
            default: ;
         endcase
      end

      if (rx_end) begin
         state_n = IDLE;
         tx_n    = 8'h00;
      end

      inc  = {1'b0, unk} + {1'b0, abort};
      esum = {1'b0, err_count} + (ERR_W+1)'(inc);
      err_n = esum[ERR_W] ? {ERR_W{1'b1}} : esum[ERR_W-1:0];
   end

endmodule
